run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Moore-style run controller that sequences one shared processing engine through arm, run, drain and completion phases. It accepts a start pulse from software or a host FSM and drives the engine enable. It supervises the engine's busy/error handshake with a programmable arm timeout and a fixed drain window, then reports completion with a done pulse and sticky status flags. It sits between the control register block and the engine datapath.

Parameters:
TIMEOUT_W, 8, width of the arm-timeout counter and of timeout_cfg.
DRAIN_CYCLES, 4, minimum cycles eng_en stays low in DRAIN before DONE is allowed. Must be >= 1.

Ports:
clk  input  1  clock; all logic rising-edge.
rstn  input  1  synchronous, active-low reset.
start  input  1  request a run; honoured only in IDLE.
stop  input  1  abort request; honoured in ARM and RUN.
timeout_cfg  input  TIMEOUT_W  arm timeout; sampled on accepted start.
eng_busy  input  1  engine reports active.
eng_err  input  1  engine error indication.
eng_en  output  1  engine enable.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
timed_out  output  1  sticky: last run aborted by arm timeout.
err_flag  output  1  sticky: eng_err seen during last run.
state_o  output  3  current state encoding, for debug.

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk.
- Reset (rstn=0 at a clk edge):
  - state=IDLE; counter=0.
  - eng_en=0, busy=0, done=0, timed_out=0, err_flag=0, state_o=0.
  - Reset mid-run returns to IDLE on the next edge; no done pulse is generated.
- State encodings: IDLE=0, ARM=1, RUN=2, DRAIN=3, DONE=4. Other codes are unreachable and go to IDLE.
- All outputs are registered or decoded from the state register only.
  - eng_en=1 in ARM and RUN.
  - done=1 only in DONE.
  - No combinational input-to-output paths.
- IDLE:
  - start=1 -> ARM next cycle; counter<=timeout_cfg; timed_out<=0; err_flag<=0.
  - stop, eng_busy and eng_err are ignored.
- ARM: priority order, highest first:
  1. stop -> DONE.
  2. eng_busy=1 -> RUN.
  3. counter==0 -> DONE with timed_out<=1.
  4. Otherwise counter decrements.
  - Worst-case ARM residency is timeout_cfg+1 cycles; timeout_cfg=0 gives one cycle.
- RUN:
  - eng_err=1 -> DRAIN; err_flag<=1.
  - Else stop=1 -> DRAIN.
  - Else eng_busy=0 -> DRAIN (normal completion).
  - Else stay.
  - On entry to DRAIN, counter<=DRAIN_CYCLES-1.
- DRAIN:
  - eng_en=0.
  - counter decrements to 0 and saturates there.
  - -> DONE only when counter==0 AND eng_busy==0; otherwise stay (waits indefinitely for busy to drop).
- DONE: single cycle, done=1, then -> IDLE unconditionally. start in DONE is ignored and is not queued.
- Latency:
  - start sampled at edge N gives eng_en=1 from cycle N+1.
  - Minimum start-to-done for a normal run: 1 ARM + >=1 RUN + DRAIN_CYCLES + 1 DONE.
- Simultaneous events:
  - stop+eng_busy in ARM: stop wins.
  - eng_err+stop in RUN: err_flag set.
  - start held high continuously re-arms only after passing through IDLE (one IDLE cycle minimum).
- Sticky flags hold through DONE and IDLE until the next accepted start or reset.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles with start=1 -> all outputs 0, state_o=0. Release -> ARM on the following edge.
2. Normal run (timeout_cfg=5, DRAIN_CYCLES=4):
   - Stimulus: start at cycle 0; eng_busy=1 at cycle 2; eng_busy=0 at cycle 10.
   - Response: eng_en high cycles 1-10; DRAIN cycles 11-14; done=1 at cycle 15; flags 0.
3. Arm timeout (timeout_cfg=3, eng_busy held 0): ARM for 4 cycles (1-4) -> DONE at cycle 5, timed_out=1, eng_en never entered RUN. A subsequent start clears timed_out.
4. Engine error in RUN: eng_err pulse for 1 cycle -> DRAIN next cycle, err_flag=1. With eng_busy held 1 for 6 more cycles, done is delayed until busy drops and the drain count has expired.
5. Aborts:
   - stop in ARM -> DONE next cycle, timed_out=0.
   - stop in RUN -> DRAIN, then done after DRAIN_CYCLES with eng_busy=0.
   - stop in IDLE -> no state change.
6. Corner cases:
   - timeout_cfg=0 with no busy -> timeout after exactly 1 ARM cycle.
   - Reset asserted during DRAIN -> IDLE next edge, no done pulse.
   - start asserted during DONE -> ignored; state returns to IDLE.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: Moore run controller for one shared processing engine.
// Walks the engine through IDLE -> ARM -> RUN -> DRAIN -> DONE. ARM waits for
// the engine to report busy, bounded by a programmable timeout. DRAIN keeps
// the engine disabled for a fixed minimum window and until busy drops.
//
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   start        run request, honoured in IDLE only
//   stop         abort request, honoured in ARM and RUN
//   timeout_cfg  arm timeout, captured when start is accepted
//   eng_busy     engine active
//   eng_err      engine error
//   eng_en       engine enable (ARM, RUN)
//   busy         controller not idle
//   done         one-cycle completion pulse (DONE)
//   timed_out    sticky: last run ended by arm timeout
//   err_flag     sticky: eng_err seen during last run
//   state_o      current state code, for debug
module run_sequencer #(
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  input  logic                 eng_busy,
  input  logic                 eng_err,
  output logic                 eng_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic                 err_flag,
  output logic [2:0]           state_o
);

  // One counter serves both the arm timeout and the drain window, so it must
  // be wide enough for either load value.
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CntW   = (TIMEOUT_W > DrainW) ? TIMEOUT_W : DrainW;

  localparam logic [CntW-1:0] DrainInit = CntW'(DRAIN_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed_out_q, timed_out_d;
  logic            err_flag_q, err_flag_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    err_flag_d  = err_flag_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StArm;
          cnt_d       = CntW'(timeout_cfg);
          timed_out_d = 1'b0;
          err_flag_d  = 1'b0;
        end
      end
      StArm: begin
        if (stop) begin
          state_d = StDone;
        end else if (eng_busy) begin
          state_d = StRun;
        end else if (cnt_q == '0) begin
          state_d     = StDone;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StRun: begin
        // Error takes precedence so a simultaneous stop still records it.
        if (eng_err) begin
          state_d    = StDrain;
          cnt_d      = DrainInit;
          err_flag_d = 1'b1;
        end else if (stop || !eng_busy) begin
          state_d = StDrain;
          cnt_d   = DrainInit;
        end
      end
      StDrain: begin
        // Counter saturates at zero; exit also waits for the engine to idle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (!eng_busy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign eng_en    = (state_q == StArm) || (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign timed_out = timed_out_q;
  assign err_flag  = err_flag_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with default parameters (TIMEOUT_W=8,
// DRAIN_CYCLES=4). Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, so "cycle k" means the interval after edge k.
module tb_run_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic [7:0] timeout_cfg;
  logic       eng_busy;
  logic       eng_err;
  logic       eng_en;
  logic       busy;
  logic       done;
  logic       timed_out;
  logic       err_flag;
  logic [2:0] state_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] SI = 3'd0, SA = 3'd1, SR = 3'd2, SD = 3'd3, SN = 3'd4;

  run_sequencer #(
    .TIMEOUT_W   (8),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .timeout_cfg(timeout_cfg),
    .eng_busy   (eng_busy),
    .eng_err    (eng_err),
    .eng_en     (eng_en),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .err_flag   (err_flag),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output at once: {eng_en, busy, done, timed_out, err_flag, state_o}.
  task automatic chk(input string tag, input logic [2:0] st, input logic to, input logic er);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {eng_en, busy, done, timed_out, err_flag, state_o};
    exp = {(st == SA) || (st == SR), st != SI, st == SN, to, er, st};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b1;
    stop        = 1'b0;
    timeout_cfg = 8'd0;
    eng_busy    = 1'b0;
    eng_err     = 1'b0;

    // 1. Reset held 3 cycles with start high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", SI, 1'b0, 1'b0);
    end
    rstn = 1'b1;
    tick();
    chk("rel_arm", SA, 1'b0, 1'b0);
    // timeout_cfg=0: exactly one ARM cycle, then timeout.
    tick();
    chk("to0_done", SN, 1'b1, 1'b0);
    // start still high in DONE is ignored.
    tick();
    chk("done_start_ign", SI, 1'b1, 1'b0);
    // Held start re-arms after the IDLE cycle and clears timed_out.
    tick();
    chk("rearm", SA, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    chk("rearm_to", SN, 1'b1, 1'b0);
    tick();
    chk("rearm_idle", SI, 1'b1, 1'b0);

    // 2. Normal run, timeout_cfg=5.
    timeout_cfg = 8'd5;
    start = 1'b1;
    tick();
    chk("norm_c1", SA, 1'b0, 1'b0);
    start = 1'b0;
    timeout_cfg = 8'd0;  // captured value must be used, not the live input
    tick();
    chk("norm_c2", SA, 1'b0, 1'b0);
    eng_busy = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      tick();
      chk($sformatf("norm_run_c%0d", c), SR, 1'b0, 1'b0);
    end
    eng_busy = 1'b0;
    for (int c = 11; c <= 14; c++) begin
      tick();
      chk($sformatf("norm_drain_c%0d", c), SD, 1'b0, 1'b0);
    end
    tick();
    chk("norm_done_c15", SN, 1'b0, 1'b0);
    tick();
    chk("norm_idle_c16", SI, 1'b0, 1'b0);

    // 3. Arm timeout, timeout_cfg=3: ARM cycles 1-4, DONE at 5.
    timeout_cfg = 8'd3;
    start = 1'b1;
    tick();
    chk("to3_c1", SA, 1'b0, 1'b0);
    start = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("to3_arm_c%0d", c), SA, 1'b0, 1'b0);
    end
    tick();
    chk("to3_done_c5", SN, 1'b1, 1'b0);
    tick();
    chk("to3_idle_sticky", SI, 1'b1, 1'b0);

    // 4. Engine error in RUN, busy held through the drain window.
    timeout_cfg = 8'd5;
    start = 1'b1;
    tick();
    chk("err_arm_clr_to", SA, 1'b0, 1'b0);
    start = 1'b0;
    eng_busy = 1'b1;
    tick();
    chk("err_run", SR, 1'b0, 1'b0);
    eng_err = 1'b1;
    tick();
    chk("err_drain_c3", SD, 1'b0, 1'b1);
    eng_err = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      tick();
      chk($sformatf("err_drain_c%0d", c), SD, 1'b0, 1'b1);
    end
    eng_busy = 1'b0;
    tick();
    chk("err_done", SN, 1'b0, 1'b1);
    tick();
    chk("err_idle_sticky", SI, 1'b0, 1'b1);

    // 5a. stop in ARM together with busy: stop wins, DONE next cycle.
    start = 1'b1;
    tick();
    chk("stoparm_arm", SA, 1'b0, 1'b0);
    start = 1'b0;
    stop = 1'b1;
    eng_busy = 1'b1;
    tick();
    chk("stoparm_done", SN, 1'b0, 1'b0);
    stop = 1'b0;
    eng_busy = 1'b0;
    tick();
    chk("stoparm_idle", SI, 1'b0, 1'b0);

    // 5b. stop in RUN with busy still high.
    start = 1'b1;
    tick();
    start = 1'b0;
    eng_busy = 1'b1;
    tick();
    chk("stoprun_run", SR, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    chk("stoprun_drain", SD, 1'b0, 1'b0);
    stop = 1'b0;
    eng_busy = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk($sformatf("stoprun_drain_c%0d", c), SD, 1'b0, 1'b0);
    end
    tick();
    chk("stoprun_done", SN, 1'b0, 1'b0);
    tick();
    chk("stoprun_idle", SI, 1'b0, 1'b0);

    // 5c. stop, busy and err in IDLE are ignored.
    stop = 1'b1;
    eng_busy = 1'b1;
    eng_err = 1'b1;
    tick();
    chk("stopidle_1", SI, 1'b0, 1'b0);
    tick();
    chk("stopidle_2", SI, 1'b0, 1'b0);
    stop = 1'b0;
    eng_err = 1'b0;

    // 6. err+stop in RUN sets err_flag; then reset during DRAIN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("errstop_run", SR, 1'b0, 1'b0);
    stop = 1'b1;
    eng_err = 1'b1;
    tick();
    chk("errstop_drain", SD, 1'b0, 1'b1);
    stop = 1'b0;
    eng_err = 1'b0;
    eng_busy = 1'b0;
    rstn = 1'b0;
    tick();
    chk("rst_in_drain", SI, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    chk("rst_no_done", SI, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
